// File: rtl/cond_xor_checker_pkg.sv
// Shared types and helpers for the gated-XOR stream checker.
package cond_xor_checker_pkg;

  // Checker FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Width of a captured stimulus/response vector
  localparam int unsigned VecW = 4;

  // Vector field order is {en, a, b, q}
  function automatic logic [VecW-1:0] pack_vec(input logic en, input logic a, input logic b,
                                               input logic q);
    return {en, a, b, q};
  endfunction

endpackage

// File: rtl/cond_xor_checker_if.sv
// Stimulus, observed result and verdict signals of the gated-XOR checker.
interface cond_xor_checker_if #(
  parameter int unsigned CNT_W = 8
);
  import cond_xor_checker_pkg::*;

  logic             start;
  logic             en;
  logic             a;
  logic             b;
  logic             q;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] first_err_idx;
  logic [VecW-1:0]  first_err_vec;
  logic             first_err_vld;

  // Stimulus side: drives the stream, reads the verdict
  modport master (
    output start, en, a, b, q,
    input  busy, done, pass, err_count, sample_count, first_err_idx, first_err_vec,
           first_err_vld
  );

  // Checker side
  modport slave (
    input  start, en, a, b, q,
    output busy, done, pass, err_count, sample_count, first_err_idx, first_err_vec,
           first_err_vld
  );
endinterface

// File: rtl/cond_xor_model.sv
// Golden gated-XOR: exp = en ? a ^ b : 0. Purely combinational.
module cond_xor_model (
  input  logic en_i,
  input  logic a_i,
  input  logic b_i,
  output logic exp_o
);

  // Reference function of the stream under check
  always_comb begin
    exp_o = en_i & (a_i ^ b_i);
  end

endmodule

// File: rtl/cond_xor_checker.sv
// Samples {en,a,b,q} once per clock during a run, counts mismatches against the
// gated-XOR model, captures the first failing vector and reports a verdict.
module cond_xor_checker
  import cond_xor_checker_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  cond_xor_checker_if.slave   bus
);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] sample_count_q, sample_count_d;
  logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
  logic [VecW-1:0]  first_err_vec_q, first_err_vec_d;
  logic             first_err_vld_q, first_err_vld_d;

  logic exp_w;
  logic mismatch;

  cond_xor_model u_model (
    .en_i  (bus.en),
    .a_i   (bus.a),
    .b_i   (bus.b),
    .exp_o (exp_w)
  );

  // 4-state compare so an X/Z on q in simulation is flagged as a mismatch
  assign mismatch = (bus.q !== exp_w);

  // Next-state, counter and capture logic
  always_comb begin
    state_d         = state_q;
    pass_d          = pass_q;
    err_count_d     = err_count_q;
    sample_count_d  = sample_count_q;
    first_err_idx_d = first_err_idx_q;
    first_err_vec_d = first_err_vec_q;
    first_err_vld_d = first_err_vld_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d         = StRun;
          pass_d          = 1'b0;
          err_count_d     = '0;
          sample_count_d  = '0;
          first_err_idx_d = '0;
          first_err_vec_d = '0;
          first_err_vld_d = 1'b0;
        end
      end
      StRun: begin
        sample_count_d = sample_count_q + 1'b1;
        if (mismatch) begin
          if (err_count_q != '1) begin
            err_count_d = err_count_q + 1'b1;
          end
          if (!first_err_vld_q) begin
            first_err_idx_d = sample_count_q;
            first_err_vec_d = pack_vec(bus.en, bus.a, bus.b, bus.q);
            first_err_vld_d = 1'b1;
          end
        end
        // Verdict includes the final sample's contribution
        if (sample_count_q == CNT_W'(NUM_SAMPLES - 1)) begin
          state_d = StDone;
          pass_d  = (err_count_d == '0);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_count_q     <= '0;
      sample_count_q  <= '0;
      first_err_idx_q <= '0;
      first_err_vec_q <= '0;
      first_err_vld_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      err_count_q     <= err_count_d;
      sample_count_q  <= sample_count_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_vec_q <= first_err_vec_d;
      first_err_vld_q <= first_err_vld_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_count_q;
  assign bus.sample_count  = sample_count_q;
  assign bus.first_err_idx = first_err_idx_q;
  assign bus.first_err_vec = first_err_vec_q;
  assign bus.first_err_vld = first_err_vld_q;

endmodule

// File: tb/tb_cond_xor_checker.sv
// Directed bench for cond_xor_checker: table of 8-sample runs plus hand-written
// reset, mid-run reset and saturation sequences.
module tb_cond_xor_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cond_xor_checker_if #(.CNT_W(8)) ifc ();
  cond_xor_checker_if #(.CNT_W(2)) ifs ();

  cond_xor_checker #(.NUM_SAMPLES(8), .CNT_W(8)) uut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  cond_xor_checker #(.NUM_SAMPLES(3), .CNT_W(2)) uut_sat (
    .clk (clk),
    .rst (rst),
    .bus (ifs.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] fault_mask;  // bit i set: invert q at sample i
    int         extra_start; // sample index at which start is also raised (8 = none)
    logic [7:0] exp_err;
    logic       exp_pass;
    logic       exp_vld;
    logic [7:0] exp_idx;
    logic [3:0] exp_vec;
  } run_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic ref_q(input logic en, input logic a, input logic b);
    return en ? (a ^ b) : 1'b0;
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, " busy"}, 32'(ifc.busy), 0);
    check({tag, " done"}, 32'(ifc.done), 0);
    check({tag, " pass"}, 32'(ifc.pass), 0);
    check({tag, " err_count"}, 32'(ifc.err_count), 0);
    check({tag, " sample_count"}, 32'(ifc.sample_count), 0);
    check({tag, " first_err_vld"}, 32'(ifc.first_err_vld), 0);
    check({tag, " first_err_idx"}, 32'(ifc.first_err_idx), 0);
    check({tag, " first_err_vec"}, 32'(ifc.first_err_vec), 0);
  endtask

  // Start pulse, then {en,a,b} = 0..7 with q from the reference, faults per mask
  task automatic do_run(input run_t r, input int id);
    logic [2:0] v;
    @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      v = 3'(i);
      ifc.start = (i == r.extra_start);
      ifc.en = v[2];
      ifc.a  = v[1];
      ifc.b  = v[0];
      ifc.q  = ref_q(v[2], v[1], v[0]) ^ r.fault_mask[i];
      if (i == 4) check($sformatf("run%0d busy mid", id), 32'(ifc.busy), 1);
      if (i == 7) check($sformatf("run%0d done early", id), 32'(ifc.done), 0);
    end
    @(negedge clk);
    ifc.start = 1'b0;
    check($sformatf("run%0d done", id), 32'(ifc.done), 1);
    check($sformatf("run%0d busy", id), 32'(ifc.busy), 0);
    check($sformatf("run%0d sample_count", id), 32'(ifc.sample_count), 8);
    check($sformatf("run%0d err_count", id), 32'(ifc.err_count), 32'(r.exp_err));
    check($sformatf("run%0d pass", id), 32'(ifc.pass), 32'(r.exp_pass));
    check($sformatf("run%0d first_err_vld", id), 32'(ifc.first_err_vld), 32'(r.exp_vld));
    check($sformatf("run%0d first_err_idx", id), 32'(ifc.first_err_idx), 32'(r.exp_idx));
    check($sformatf("run%0d first_err_vec", id), 32'(ifc.first_err_vec), 32'(r.exp_vec));
    // Results held in DONE
    @(negedge clk);
    check($sformatf("run%0d done hold", id), 32'(ifc.done), 1);
    check($sformatf("run%0d count hold", id), 32'(ifc.sample_count), 8);
    check($sformatf("run%0d err hold", id), 32'(ifc.err_count), 32'(r.exp_err));
  endtask

  run_t runs [5];

  initial begin
    run_t clean;
    runs[0] = '{8'h00, 8, 8'd0, 1'b1, 1'b0, 8'd0, 4'b0000};
    runs[1] = '{8'h20, 8, 8'd1, 1'b0, 1'b1, 8'd5, 4'b1010};
    runs[2] = '{8'h44, 3, 8'd2, 1'b0, 1'b1, 8'd2, 4'b0101};
    runs[3] = '{8'h81, 7, 8'd2, 1'b0, 1'b1, 8'd0, 4'b0001};
    runs[4] = '{8'h00, 7, 8'd0, 1'b1, 1'b0, 8'd0, 4'b0000};
    clean   = runs[0];

    {ifc.start, ifc.en, ifc.a, ifc.b, ifc.q} = '0;
    {ifs.start, ifs.en, ifs.a, ifs.b, ifs.q} = '0;

    // Reset then idle
    repeat (2) @(negedge clk);
    check_cleared("in reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_cleared("idle");

    // Saturation: CNT_W=2, 3 samples, q inverted every sample
    ifs.start = 1'b1;
    @(negedge clk);
    ifs.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      ifs.en = 1'b0;
      ifs.a  = i[0];
      ifs.b  = 1'b0;
      ifs.q  = ~ref_q(1'b0, i[0], 1'b0);
    end
    @(negedge clk);
    check("sat done", 32'(ifs.done), 1);
    check("sat err_count", 32'(ifs.err_count), 3);
    check("sat sample_count", 32'(ifs.sample_count), 3);
    check("sat pass", 32'(ifs.pass), 0);
    check("sat first_err_idx", 32'(ifs.first_err_idx), 0);
    check("sat first_err_vec", 32'(ifs.first_err_vec), 32'b0001);

    // Table of runs: first from IDLE, remaining restart from DONE
    for (int k = 0; k < 5; k++) do_run(runs[k], k);

    // Reset mid-run after 3 samples (one faulty)
    @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      ifc.en = 1'b1;
      ifc.a  = 1'b1;
      ifc.b  = i[0];
      ifc.q  = ref_q(1'b1, 1'b1, i[0]) ^ (i == 1);
    end
    @(negedge clk);
    check("midrun sample_count", 32'(ifc.sample_count), 3);
    check("midrun err_count", 32'(ifc.err_count), 1);
    check("midrun busy", 32'(ifc.busy), 1);
    #2 rst = 1'b1;
    #1 check_cleared("midrun reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_cleared("after midrun reset");
    do_run(clean, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute guard against a hang
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish by 100000");
    $fatal(1);
  end

endmodule
